// File: rtl/generic_fifo_sc_async_pkg.sv
// -----------------------------------------------------------------------------
// generic_fifo_sc_async_pkg
// Shared types for the single-clock FIFO.
//   fifo_op_e : the kind of pointer/count update that happens at one clock edge.
//   fifo_op() : builds that update kind from the gated write/read accepts.
// -----------------------------------------------------------------------------
package generic_fifo_sc_async_pkg;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    // Bit 0 is the write accept and bit 1 the read accept, so the encoding
    // above falls straight out of the concatenation.
    function automatic fifo_op_e fifo_op(input logic wr_ok, input logic rd_ok);
        return fifo_op_e'({rd_ok, wr_ok});
    endfunction

endpackage

// File: rtl/generic_dpram_sc.sv
// -----------------------------------------------------------------------------
// generic_dpram_sc
// Simple dual-port RAM on one clock: one write port and one registered read
// port. Written so that synthesis maps the array onto block RAM.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-low reset (clears the read register only)
//   we     in   write enable
//   waddr  in   write address
//   din    in   write data
//   re     in   read enable; dout updates on the same edge
//   raddr  in   read address
//   dout   out  registered read data, held when re=0
// -----------------------------------------------------------------------------
module generic_dpram_sc #(
    parameter int dw = 8,
    parameter int aw = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [aw-1:0] waddr,
    input  logic [dw-1:0] din,
    input  logic          re,
    input  logic [aw-1:0] raddr,
    output logic [dw-1:0] dout
);

    localparam int DEPTH = 1 << aw;

    logic [dw-1:0] r_mem [DEPTH];
    logic [dw-1:0] r_dout;

    // NOTE: the storage array has no reset; resetting it would block the
    // block-RAM mapping, and the pointers already make stale words unreachable.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= din;
        end
    end

    // The output register is kept separate from the array so it can carry
    // an asynchronous reset without affecting the RAM inference.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout <= '0;
        end else if (re) begin
            r_dout <= r_mem[raddr];
        end
    end

    assign dout = r_dout;

endmodule

// File: rtl/generic_fifo_sc_async.sv
// -----------------------------------------------------------------------------
// generic_fifo_sc_async
// Single-clock FIFO with registered (non-FWFT) read data, fill count and a
// programmable almost-full flag. Stands in for the vendor dual-clock FIFO
// macro when both sides share a clock; a FWFT wrapper sits on top of it.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-low reset
//   clr          in   synchronous clear; empties the FIFO, dout is held
//   din          in   write data
//   we           in   write request (ignored when full)
//   re           in   read request (ignored when empty); dout valid next clk
//   dout         out  registered read data
//   full         out  fillcount == DEPTH
//   empty        out  fillcount == 0
//   afull        out  fillcount >= ALMOST_FULL
//   afull_n      out  ~afull
//   o_afull_n_d  out  afull_n delayed by one clock
//   fillcount    out  stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module generic_fifo_sc_async
    import generic_fifo_sc_async_pkg::*;
#(
    parameter int dw          = 8,
    parameter int aw          = 4,
    parameter int ALMOST_FULL = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [dw-1:0] din,
    input  logic          we,
    input  logic          re,
    output logic [dw-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic          afull,
    output logic          afull_n,
    output logic          o_afull_n_d,
    output logic [aw:0]   fillcount
);

    localparam int            DEPTH     = 1 << aw;
    localparam logic [aw:0]   CNT_FULL  = (aw+1)'(DEPTH);
    localparam logic [aw:0]   CNT_AFULL = (aw+1)'(ALMOST_FULL);
    localparam logic [aw-1:0] PTR_ONE   = aw'(1);
    localparam logic [aw:0]   CNT_ONE   = (aw+1)'(1);

    if (ALMOST_FULL < 1 || ALMOST_FULL > DEPTH) begin : g_bad_almost_full
        $fatal(1, "generic_fifo_sc_async: ALMOST_FULL must be in 1..2**aw");
    end

    logic [aw-1:0] r_wr_ptr;
    logic [aw-1:0] r_rd_ptr;
    logic [aw:0]   r_fillcount;
    logic          r_afull_n_d;

    logic          w_wr_ok;
    logic          w_rd_ok;
    fifo_op_e      w_op;
    logic [aw:0]   w_fillcount_nxt;

    // Full and empty gate the requests, so a write and read never hit the
    // same address on one edge. clr masks both so the RAM sees no activity.
    assign w_wr_ok = we & ~full  & ~clr;
    assign w_rd_ok = re & ~empty & ~clr;
    assign w_op    = fifo_op(w_wr_ok, w_rd_ok);

    // NOTE: every variable written in always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_fillcount_nxt = r_fillcount;
        case (w_op)
            OP_WRITE: w_fillcount_nxt = r_fillcount + CNT_ONE;
            OP_READ:  w_fillcount_nxt = r_fillcount - CNT_ONE;
            default:  w_fillcount_nxt = r_fillcount;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fillcount <= '0;
            r_afull_n_d <= 1'b1;
        end else if (clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fillcount <= '0;
            r_afull_n_d <= 1'b1;
        end else begin
            // Pointers are exactly aw bits wide, so +1 wraps modulo DEPTH.
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_fillcount <= w_fillcount_nxt;
            r_afull_n_d <= afull_n;
        end
    end

    generic_dpram_sc #(
        .dw (dw),
        .aw (aw)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (w_wr_ok),
        .waddr (r_wr_ptr),
        .din   (din),
        .re    (w_rd_ok),
        .raddr (r_rd_ptr),
        .dout  (dout)
    );

    // Flags decode the registered count, so they move on the same edge as it.
    assign fillcount   = r_fillcount;
    assign full        = (r_fillcount == CNT_FULL);
    assign empty       = (r_fillcount == '0);
    assign afull       = (r_fillcount >= CNT_AFULL);
    assign afull_n     = ~afull;
    assign o_afull_n_d = r_afull_n_d;

endmodule

// File: tb/tb_generic_fifo_sc_async.sv
// -----------------------------------------------------------------------------
// tb_generic_fifo_sc_async
// Self-checking bench: a queue-based reference model of the FIFO is compared
// against every DUT output after each clock, through directed sequences and a
// randomized phase with clears and an asynchronous reset.
// -----------------------------------------------------------------------------
module tb_generic_fifo_sc_async;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int AF    = 14;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          we  = 1'b0;
    logic          re  = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          full, empty, afull, afull_n, o_afull_n_d;
    logic [AW:0]   fillcount;

    generic_fifo_sc_async #(
        .dw          (DW),
        .aw          (AW),
        .ALMOST_FULL (AF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .din         (din),
        .we          (we),
        .re          (re),
        .dout        (dout),
        .full        (full),
        .empty       (empty),
        .afull       (afull),
        .afull_n     (afull_n),
        .o_afull_n_d (o_afull_n_d),
        .fillcount   (fillcount)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: contents as a queue, plus the two registered outputs.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout  = '0;
    logic          m_afn_d = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check({tag, ":fillcount"}, 32'(fillcount),   32'(n));
        check({tag, ":empty"},     32'(empty),       32'(n == 0));
        check({tag, ":full"},      32'(full),        32'(n == DEPTH));
        check({tag, ":afull"},     32'(afull),       32'(n >= AF));
        check({tag, ":afull_n"},   32'(afull_n),     32'(n < AF));
        check({tag, ":afull_n_d"}, 32'(o_afull_n_d), 32'(m_afn_d));
        check({tag, ":dout"},      32'(dout),        32'(m_dout));
    endtask

    // Model of one rising edge, using the state before the edge.
    task automatic model_edge(input bit w, input bit r, input logic [DW-1:0] d, input bit c);
        bit prev_afn;
        bit wr_ok;
        bit rd_ok;
        prev_afn = (q.size() < AF);
        wr_ok    = w && (q.size() < DEPTH);
        rd_ok    = r && (q.size() > 0);
        if (!rst) begin
            q.delete();
            m_dout  = '0;
            m_afn_d = 1'b1;
        end else if (c) begin
            q.delete();
            m_afn_d = 1'b1;
        end else begin
            m_afn_d = prev_afn;
            if (rd_ok) m_dout = q.pop_front();
            if (wr_ok) q.push_back(d);
        end
    endtask

    // Drive inputs just after an edge, clock once, then compare 1 time unit
    // after the next edge.
    task automatic cycle(input bit w, input bit r, input logic [DW-1:0] d, input bit c,
                         input string tag);
        we  = w;
        re  = r;
        din = d;
        clr = c;
        @(posedge clk);
        model_edge(w, r, d, c);
        #1;
        check_all(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] d;

        // 1. Reset held, then released and idle.
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_hold");
        rst = 1'b1;
        cycle(0, 0, 8'h00, 0, "idle");
        cycle(0, 0, 8'h00, 0, "idle");

        // 2. Fill 16 entries, afull after the 14th, then a write while full.
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1, 0, 8'(i), 0, "fill");
            if (i == 13) check("afull_before_14", 32'(afull), 32'd0);
            if (i == 14) check("afull_at_14",     32'(afull), 32'd1);
            if (i == 15) check("afull_n_d_fell",  32'(o_afull_n_d), 32'd0);
        end
        check("full_after_16", 32'(full), 32'd1);
        cycle(1, 0, 8'hAA, 0, "wr_full");
        check("wr_full_count", 32'(fillcount), 32'd16);

        // 3. Drain in order, then a read while empty.
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(0, 1, 8'h00, 0, "drain");
            check("drain_order", 32'(dout), 32'(i));
        end
        check("empty_after_drain", 32'(empty), 32'd1);
        cycle(0, 1, 8'h00, 0, "rd_empty");
        check("rd_empty_dout", 32'(dout), 32'h10);

        // 4. Fill to 8, then 20 simultaneous read/write cycles across the wrap.
        d = 8'h20;
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, d, 0, "fill8");
            d = d + 8'd1;
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1, 1, d, 0, "stream");
            check("stream_dout", 32'(dout), 32'(8'h20 + 8'(i)));
            d = d + 8'd1;
        end

        // 5. Empty FIFO with we=re=1: write only, no bypass.
        while (q.size() > 0) cycle(0, 1, 8'h00, 0, "drain2");
        d = m_dout;
        cycle(1, 1, 8'h55, 0, "wr_rd_empty");
        check("no_bypass_count", 32'(fillcount), 32'd1);
        check("no_bypass_dout",  32'(dout),      32'(d));
        cycle(0, 1, 8'h00, 0, "read_55");
        check("read_55_dout", 32'(dout), 32'h55);

        // 6. Fill 5, clear, then async reset mid-burst.
        for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'h60 + i), 0, "fill5");
        d = dout;
        cycle(1, 1, 8'h77, 1, "clr");
        check("clr_count", 32'(fillcount), 32'd0);
        check("clr_dout",  32'(dout),      32'(d));
        for (int i = 0; i < 6; i++) begin
            cycle(1, ($urandom_range(0, 3) == 0), 8'($urandom), 0, "burst");
        end
        #2;
        rst = 1'b0;
        q.delete();
        m_dout  = '0;
        m_afn_d = 1'b1;
        #1;
        check_all("async_rst");
        cycle(1, 1, 8'h99, 0, "in_rst");
        #1;
        rst = 1'b1;
        cycle(1, 0, 8'h3C, 0, "post_rst_wr");
        cycle(0, 1, 8'h00, 0, "post_rst_rd");
        check("post_rst_first", 32'(dout), 32'h3C);

        // Randomized traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            cycle(bit'($urandom_range(0, 99) < 55), bit'($urandom_range(0, 99) < 45),
                  8'($urandom), bit'($urandom_range(0, 49) == 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
